// File: rtl/alu_multicycle.sv
// Multi-cycle EXE-stage ALU: single-cycle logic/add/shift/compare ops, iterative
// shift-add multiply and restoring divide, valid/ready handshakes on both sides.
module alu_multicycle #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             ovf,
   output logic             div_zero
);

   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = $clog2(WIDTH) + 1;

   localparam logic [3:0] OP_SHL  = 4'h0, OP_SHR  = 4'h1, OP_MUL  = 4'h2, OP_MULU = 4'h3,
                          OP_DIV  = 4'h4, OP_DIVU = 4'h5, OP_ADD  = 4'h6, OP_ADDU = 4'h7,
                          OP_SUB  = 4'h8, OP_SUBU = 4'h9, OP_AND  = 4'hA, OP_OR   = 4'hB,
                          OP_XOR  = 4'hC, OP_NOR  = 4'hD, OP_SLT  = 4'hE, OP_SLTU = 4'hF;

   localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t state;

   logic [3:0]       op_p0;
   logic [WIDTH-1:0] a_p0, b_p0, mag_p0;
   logic [WIDTH-1:0] acc_hi, acc_lo;
   logic [CW-1:0]    cnt;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
      return (sgn && x[WIDTH-1]) ? -x : x;
   endfunction

   logic in_mul, in_div, in_sgn, in_long;

   assign in_mul  = (alu_sel == OP_MUL) || (alu_sel == OP_MULU);
   assign in_div  = (alu_sel == OP_DIV) || (alu_sel == OP_DIVU);
   assign in_sgn  = (alu_sel == OP_MUL) || (alu_sel == OP_DIV);
   assign in_long = in_mul || (in_div && (b != '0));

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // One iteration step: mul adds the multiplicand when the low multiplier bit is set,
   // div trial-subtracts the divisor from the shifted partial remainder.
   logic [WIDTH:0] mul_sum, div_trial;

   assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mag_p0 : '0)};
   assign div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, mag_p0};

   logic signed [WIDTH-1:0] a_s, b_s;
   logic                    neg_q, neg_r;
   logic [2*WIDTH-1:0]      prod_raw, prod_fin;
   logic [WIDTH:0]          sum_w;
   logic [WIDTH-1:0]        diff_w;

   assign a_s      = a_p0;
   assign b_s      = b_p0;
   assign neg_q    = a_p0[WIDTH-1] ^ b_p0[WIDTH-1];
   assign neg_r    = a_p0[WIDTH-1];
   assign prod_raw = {acc_hi, acc_lo};
   assign prod_fin = (op_p0 == OP_MUL && neg_q) ? -prod_raw : prod_raw;
   assign sum_w    = {1'b0, a_p0} + {1'b0, b_p0};
   assign diff_w   = a_p0 - b_p0;

   logic [WIDTH-1:0] fin_lo, fin_hi;
   logic             fin_ovf, fin_dz;

   always_comb begin
      fin_lo  = '0;
      fin_hi  = '0;
      fin_ovf = 1'b0;
      fin_dz  = 1'b0;
      case (op_p0)
         OP_SHL:  fin_lo = a_p0 << b_p0[SHW-1:0];
         OP_SHR:  fin_lo = a_p0 >> b_p0[SHW-1:0];
         OP_MUL, OP_MULU: begin
            fin_lo = prod_fin[WIDTH-1:0];
            fin_hi = prod_fin[2*WIDTH-1:WIDTH];
         end
         OP_DIV, OP_DIVU: begin
            if (b_p0 == '0) begin
               fin_lo = '1;
               fin_hi = a_p0;
               fin_dz = 1'b1;
            end else if (op_p0 == OP_DIV) begin
               // Quotient truncates toward zero; remainder follows the dividend's sign.
               fin_lo  = neg_q ? -acc_lo : acc_lo;
               fin_hi  = neg_r ? -acc_hi : acc_hi;
               fin_ovf = (a_p0 == MIN_V) && (b_p0 == '1);
            end else begin
               fin_lo = acc_lo;
               fin_hi = acc_hi;
            end
         end
         OP_ADD: begin
            fin_lo  = sum_w[WIDTH-1:0];
            fin_ovf = (a_p0[WIDTH-1] == b_p0[WIDTH-1]) && (sum_w[WIDTH-1] != a_p0[WIDTH-1]);
         end
         OP_ADDU: begin
            fin_lo  = sum_w[WIDTH-1:0];
            fin_ovf = sum_w[WIDTH];
         end
         OP_SUB: begin
            fin_lo  = diff_w;
            fin_ovf = (a_p0[WIDTH-1] != b_p0[WIDTH-1]) && (diff_w[WIDTH-1] != a_p0[WIDTH-1]);
         end
         OP_SUBU: begin
            fin_lo  = diff_w;
            fin_ovf = (a_p0 < b_p0);
         end
         OP_AND:  fin_lo = a_p0 & b_p0;
         OP_OR:   fin_lo = a_p0 | b_p0;
         OP_XOR:  fin_lo = a_p0 ^ b_p0;
         OP_NOR:  fin_lo = ~(a_p0 | b_p0);
         OP_SLT:  fin_lo = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
         OP_SLTU: fin_lo = {{(WIDTH-1){1'b0}}, (a_p0 < b_p0)};
      endcase
   end

   // Every op passes through BUSY; short ops enter with cnt==0 and finalise next edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         result    <= '0;
         result_hi <= '0;
         zero      <= 1'b0;
         ovf       <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_p0  <= alu_sel;
                  a_p0   <= a;
                  b_p0   <= b;
                  acc_hi <= '0;
                  cnt    <= in_long ? CW'(WIDTH) : '0;
                  if (in_mul) begin
                     mag_p0 <= mag(a, in_sgn);
                     acc_lo <= mag(b, in_sgn);
                  end else begin
                     mag_p0 <= mag(b, in_sgn);
                     acc_lo <= mag(a, in_sgn);
                  end
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
                  if (op_p0 == OP_MUL || op_p0 == OP_MULU) begin
                     acc_hi <= mul_sum[WIDTH:1];
                     acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                  end else if (!div_trial[WIDTH]) begin
                     acc_hi <= div_trial[WIDTH-1:0];
                     acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                  end else begin
                     acc_hi <= {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                     acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  result    <= fin_lo;
                  result_hi <= fin_hi;
                  zero      <= (fin_lo == '0);
                  ovf       <= fin_ovf;
                  div_zero  <= fin_dz;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: driver pushes model results on accept,
// negedge monitor checks latency, outputs, stability and in_ready.
module tb_alu_multicycle;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0, b = '0;
   logic [3:0]    alu_sel = 4'h0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  result, result_hi;
   logic          zero, ovf, div_zero;

   typedef struct {
      logic [31:0] res;
      logic [31:0] hi;
      logic        zero;
      logic        ovf;
      logic        dz;
      int          lat;
      int          acc;
      logic [3:0]  op;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   last_pop = -10;
   int   errors = 0;
   int   checks = 0;
   int   hold = 0;
   bit   prev_ov = 1'b0;
   bit   rand_bp = 1'b0;

   alu_multicycle #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .alu_sel(alu_sel), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result_hi(result_hi), .zero(zero), .ovf(ovf), .div_zero(div_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, longint unsigned act, longint unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Reference model: plain 64-bit arithmetic on the architectural definition.
   function automatic exp_t model(logic [3:0] op, logic [31:0] x, logic [31:0] y);
      exp_t            e;
      longint          sx, sy, t;
      longint unsigned ux, uy, u;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'h0, x};
      uy = {32'h0, y};
      e.res = '0; e.hi = '0; e.ovf = 1'b0; e.dz = 1'b0; e.lat = 1; e.acc = 0; e.op = op;
      case (op)
         4'h0: e.res = x << y[4:0];
         4'h1: e.res = x >> y[4:0];
         4'h2: begin t = sx * sy; {e.hi, e.res} = t; e.lat = 33; end
         4'h3: begin u = ux * uy; {e.hi, e.res} = u; e.lat = 33; end
         4'h4, 4'h5: begin
            if (y == 0) begin
               e.res = 32'hFFFFFFFF; e.hi = x; e.dz = 1'b1;
            end else begin
               e.lat = 33;
               if (op == 4'h5) begin
                  u = ux / uy; e.res = u[31:0];
                  u = ux % uy; e.hi  = u[31:0];
               end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
                  e.res = x; e.hi = 0; e.ovf = 1'b1;
               end else begin
                  t = sx / sy; e.res = t[31:0];
                  t = sx % sy; e.hi  = t[31:0];
               end
            end
         end
         4'h6: begin t = sx + sy; e.res = t[31:0]; e.ovf = (t != longint'($signed(t[31:0]))); end
         4'h7: begin u = ux + uy; e.res = u[31:0]; e.ovf = u[32]; end
         4'h8: begin t = sx - sy; e.res = t[31:0]; e.ovf = (t != longint'($signed(t[31:0]))); end
         4'h9: begin e.res = x - y; e.ovf = (ux < uy); end
         4'hA: e.res = x & y;
         4'hB: e.res = x | y;
         4'hC: e.res = x ^ y;
         4'hD: e.res = ~(x | y);
         4'hE: e.res = (sx < sy) ? 32'd1 : 32'd0;
         4'hF: e.res = (ux < uy) ? 32'd1 : 32'd0;
      endcase
      e.zero = (e.res == 0);
      return e;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         5: return $urandom_range(0, 40);
         default: return $urandom();
      endcase
   endfunction

   // Monitor
   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", in_ready, (q.size() == 0 && last_pop != cyc));
         if (out_valid) begin
            if (q.size() == 0) begin
               errors++; checks++;
               $display("FAIL unexpected_output: got result %0h with nothing outstanding", result);
            end else begin
               if (!prev_ov) chk($sformatf("latency op%0h", q[0].op), cyc - q[0].acc, q[0].lat);
               chk($sformatf("result op%0h", q[0].op), result, q[0].res);
               chk($sformatf("result_hi op%0h", q[0].op), result_hi, q[0].hi);
               chk($sformatf("zero op%0h", q[0].op), zero, q[0].zero);
               chk($sformatf("ovf op%0h", q[0].op), ovf, q[0].ovf);
               chk($sformatf("div_zero op%0h", q[0].op), div_zero, q[0].dz);
               if (out_ready) begin
                  void'(q.pop_front());
                  last_pop = cyc;
               end
            end
         end
      end
      prev_ov = out_valid;
   end

   // Consumer backpressure
   initial forever begin
      @(posedge clk); #1;
      if (hold > 0) begin
         out_ready = 1'b0;
         hold--;
      end else begin
         out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
      bit   done = 1'b0;
      bit   idle;
      exp_t e;
      alu_sel  = op;
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk); #1;
         idle = (q.size() == 0) && (last_pop != cyc) && !rst;
         @(posedge clk); #1;
         if (idle) begin
            e     = model(op, av, bv);
            e.acc = cyc;
            q.push_back(e);
            done  = 1'b1;
         end
      end
      in_valid = 1'b0;
      a        = $urandom();
      b        = $urandom();
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL accept_timeout: op %0h not accepted within 300 cycles", op);
      end
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk); #1;
         if (q.size() == 0) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL drain: %0d results still pending after 500 cycles", q.size());
      end
   endtask

   task automatic check_reset_outputs(string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_result"}, result, 0);
      chk({tag, "_result_hi"}, result_hi, 0);
      chk({tag, "_flags"}, {zero, ovf, div_zero}, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      issue(4'h6, 32'h7, 32'hFFFFFFF9);
      issue(4'h6, 32'h7FFFFFFF, 32'h1);
      issue(4'h7, 32'hFFFFFFFF, 32'h1);
      issue(4'h2, 32'hFFFFFFFD, 32'h5);
      issue(4'h4, 32'hFFFFFFF9, 32'h2);
      issue(4'h5, 32'h5, 32'h0);
      issue(4'h4, 32'h80000000, 32'hFFFFFFFF);
      issue(4'h3, 32'hFFFFFFFF, 32'hFFFFFFFF);
      issue(4'h9, 32'h3, 32'h5);
      issue(4'hE, 32'hFFFFFFFF, 32'h1);
      issue(4'hF, 32'hFFFFFFFF, 32'h1);
      issue(4'h0, 32'h1, 32'h25);
      issue(4'h1, 32'h80000000, 32'h1F);
      drain();

      // Held result with a competing request pending
      issue(4'h8, 32'h3, 32'h5);
      hold = 12;
      issue(4'h6, 32'h1, 32'h2);
      drain();

      // Reset in the middle of a divide
      issue(4'h5, 32'd100, 32'd7);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      q.delete();
      @(posedge clk); #1;
      check_reset_outputs("midrst");
      rst = 1'b0;
      issue(4'h5, 32'd100, 32'd7);
      drain();

      rand_bp = 1'b1;
      for (int n = 0; n < 150; n++) begin
         issue(4'($urandom_range(0, 15)), pick(), pick());
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
